// File: rtl/exe_muldiv_seq_pkg.sv
// Shared decode constants, FSM encodings and small decode helpers for the
// multi-cycle RV32M execute unit (exe_muldiv_seq).
package exe_muldiv_seq_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] INST_MUL_F7   = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_CALC = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  // How each operand is interpreted, and whether the op uses the divider.
  typedef struct packed {
    logic op1_signed;
    logic op2_signed;
    logic is_div;
  } op_sign_t;

  function automatic op_sign_t decode_sign(input logic [2:0] funct3);
    op_sign_t s;
    s = '0;
    case (funct3)
      INST_MULH:   s = '{op1_signed: 1'b1, op2_signed: 1'b1, is_div: 1'b0};
      INST_MULHSU: s = '{op1_signed: 1'b1, op2_signed: 1'b0, is_div: 1'b0};
      INST_DIV:    s = '{op1_signed: 1'b1, op2_signed: 1'b1, is_div: 1'b1};
      INST_REM:    s = '{op1_signed: 1'b1, op2_signed: 1'b1, is_div: 1'b1};
      INST_DIVU:   s = '{op1_signed: 1'b0, op2_signed: 1'b0, is_div: 1'b1};
      INST_REMU:   s = '{op1_signed: 1'b0, op2_signed: 1'b0, is_div: 1'b1};
      default:     s = '0;
    endcase
    return s;
  endfunction

  function automatic logic is_m_inst(input logic [31:0] inst);
    return (inst[6:0] == INST_TYPE_R_M) && (inst[31:25] == INST_MUL_F7);
  endfunction

endpackage

// File: rtl/exe_muldiv_seq_muldiv_iter_core.sv
// One iteration of the shared multiply/divide datapath: UNROLL shift-add
// (multiply) or restoring shift-subtract (divide) steps, purely combinational.
// The caller holds hi/lo/operand in registers across cycles.
//   multiply: hi:lo is the running product, lo starts as the multiplier
//   divide:   hi is the partial remainder, lo shifts dividend out / quotient in
module muldiv_iter_core #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  // Chain UNROLL single-bit steps so several bits retire per cycle.
  always_comb begin
    logic [XLEN-1:0] h;
    logic [XLEN-1:0] l;
    logic [XLEN:0]   rem_s;
    logic [XLEN:0]   sum;
    h     = hi;
    l     = lo;
    rem_s = '0;
    sum   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div) begin
        rem_s = {h, l[XLEN-1]};
        if (rem_s >= {1'b0, operand}) begin
          rem_s = rem_s - {1'b0, operand};
          l     = {l[XLEN-2:0], 1'b1};
        end else begin
          l     = {l[XLEN-2:0], 1'b0};
        end
        h = rem_s[XLEN-1:0];
      end else begin
        sum    = {1'b0, h} + (l[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        {h, l} = {sum, l[XLEN-1:1]};
      end
    end
    hi_next = h;
    lo_next = l;
  end

endmodule

// File: rtl/exe_muldiv_seq.sv
// Multi-cycle RV32M execute unit with valid/ready handshake and flush.
// Operands are reduced to magnitudes at accept, iterated in muldiv_iter_core,
// and sign-corrected on the final step. Divide-by-zero, signed overflow and
// non-M instructions complete immediately.
// Optional: define EXE_MUL_SINGLE_CYCLE_EN to finish MUL* ops in one cycle
// with a combinational product; division stays iterative.
module exe_muldiv_seq
  import exe_muldiv_seq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int UNROLL      = 1,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        op1_i,
  input  logic [XLEN-1:0]        op2_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [XLEN-1:0]        reg_wdata_o,
  output logic                   busy_o
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  hi_q, lo_q, opnd_q;
  logic             res_neg_q, rem_neg_q;

  logic [2:0]       funct3_in;
  op_sign_t         sgn_in;
  logic             is_m_in, op1_neg, op2_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag, special_res;
  logic [XLEN-1:0]  hi_nx, lo_nx, final_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{inst_i[24:15], inst_i[11:7]};

  assign ready_o = (state == STATE_IDLE);
  assign valid_o = (state == STATE_DONE);
  assign busy_o  = (state != STATE_IDLE);

  // Decode the presented op into magnitudes, signs and immediate-result cases.
  always_comb begin
    funct3_in = inst_i[14:12];
    sgn_in    = decode_sign(funct3_in);
    is_m_in   = is_m_inst(inst_i);
    op1_neg   = sgn_in.op1_signed & op1_i[XLEN-1];
    op2_neg   = sgn_in.op2_signed & op2_i[XLEN-1];
    a_mag     = op1_neg ? -op1_i : op1_i;
    b_mag     = op2_neg ? -op2_i : op2_i;
    div_zero  = sgn_in.is_div && (op2_i == '0);
    div_ovf   = sgn_in.is_div && sgn_in.op1_signed &&
                (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    if (div_zero) begin
      special_res = funct3_in[1] ? op1_i : '1;
    end else begin
      special_res = funct3_in[1] ? '0 : op1_i;
    end
  end

  muldiv_iter_core #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_core (
    .is_div  (funct3_q[2]),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (opnd_q),
    .hi_next (hi_nx),
    .lo_next (lo_nx)
  );

  // Sign fix-up and half/quotient/remainder selection on the last iteration.
  always_comb begin
    prod     = {hi_nx, lo_nx};
    prod_fix = res_neg_q ? -prod : prod;
    if (funct3_q[2]) begin
      if (funct3_q[1]) begin
        final_res = rem_neg_q ? -hi_nx : hi_nx;
      end else begin
        final_res = res_neg_q ? -lo_nx : lo_nx;
      end
    end else if (funct3_q == INST_MUL) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

`ifdef EXE_MUL_SINGLE_CYCLE_EN
  logic [2*XLEN-1:0] fast_prod, fast_fix;
  logic [XLEN-1:0]   fast_res;

  // Single-cycle multiply path used straight from the accept cycle.
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_fix  = (op1_neg ^ op2_neg) ? -fast_prod : fast_prod;
    fast_res  = (funct3_in == INST_MUL) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
  end
`endif

  // Handshake FSM: accept in IDLE, iterate in CALC, hold result in DONE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= STATE_IDLE;
      cnt         <= '0;
      funct3_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
    end else if (flush_i) begin
      state <= STATE_IDLE;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (valid_i) begin
            funct3_q    <= funct3_in;
            res_neg_q   <= op1_neg ^ op2_neg;
            rem_neg_q   <= op1_neg;
            reg_waddr_o <= reg_waddr_i;
            reg_we_o    <= reg_we_i && is_m_in && (reg_waddr_i != '0);
            if (!is_m_in) begin
              reg_wdata_o <= '0;
              state       <= STATE_DONE;
            end else if (div_zero || div_ovf) begin
              reg_wdata_o <= special_res;
              state       <= STATE_DONE;
`ifdef EXE_MUL_SINGLE_CYCLE_EN
            end else if (!sgn_in.is_div) begin
              reg_wdata_o <= fast_res;
              state       <= STATE_DONE;
`endif
            end else begin
              hi_q   <= '0;
              lo_q   <= sgn_in.is_div ? a_mag : b_mag;
              opnd_q <= sgn_in.is_div ? b_mag : a_mag;
              cnt    <= CNT_W'(STEPS - 1);
              state  <= STATE_CALC;
            end
          end
        end
        STATE_CALC: begin
          hi_q <= hi_nx;
          lo_q <= lo_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            reg_wdata_o <= final_res;
            state       <= STATE_DONE;
          end
        end
        STATE_DONE: begin
          if (ready_i) begin
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Self-checking bench for exe_muldiv_seq (default build, XLEN=32, UNROLL=1).
// Results are compared against a 64-bit arithmetic reference of the RV32M rules.
module tb_exe_muldiv_seq;
  import exe_muldiv_seq_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int LAT_ITER = 1 + XLEN;
  localparam int LAT_SPECIAL = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [31:0]     inst_i = '0;
  logic [XLEN-1:0] op1_i = '0;
  logic [XLEN-1:0] op2_i = '0;
  logic [RW-1:0]   reg_waddr_i = '0;
  logic            reg_we_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [RW-1:0]   reg_waddr_o;
  logic            reg_we_o;
  logic [XLEN-1:0] reg_wdata_o;
  logic            busy_o;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  exe_muldiv_seq dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .inst_i      (inst_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .reg_we_i    (reg_we_i),
    .flush_i     (flush_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .reg_waddr_o (reg_waddr_o),
    .reg_we_o    (reg_we_o),
    .reg_wdata_o (reg_wdata_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] build_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {INST_MUL_F7, 5'd2, 5'd1, f3, rd, INST_TYPE_R_M};
  endfunction

  // Reference RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: begin p = sa * sb; w = p; return w[31:0]; end
      3'd1: begin p = sa * sb; w = p; return w[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); w = p; return w[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; w = up; return w[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; w = p; return w[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; w = p; return w[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    logic is_div, special;
    is_div  = (f3 >= 3'd4);
    special = (is_div && b == 32'd0) ||
              ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return special ? LAT_SPECIAL : LAT_ITER;
  endfunction

  // Present one op, then count negedges until valid_o appears (bounded).
  task automatic run_op(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input logic rdy,
                        output int lat, output logic [31:0] wdata, output logic we_o,
                        output logic [4:0] waddr);
    @(negedge clk);
    valid_i = 1'b1; inst_i = inst; op1_i = a; op2_i = b;
    reg_waddr_i = rd; reg_we_i = we; ready_i = rdy;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    wdata = reg_wdata_o;
    we_o  = reg_we_o;
    waddr = reg_waddr_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_count++; if (ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); else pass_count++;
    check_count++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); else pass_count++;
    check_count++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); else pass_count++;
    check_count++; if (reg_wdata_o !== 32'd0) $display("[TB] FAIL reset_wdata: got %h expected 0", reg_wdata_o); else pass_count++;
    check_count++; if ({reg_we_o, reg_waddr_o} !== 6'd0) $display("[TB] FAIL reset_we_waddr: got %b/%0d expected 0/0", reg_we_o, reg_waddr_o); else pass_count++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs[11];
    int lat; logic [31:0] wd; logic weo; logic [4:0] wa;
    vecs[0]  = '{INST_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd33};
    vecs[1]  = '{INST_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33};
    vecs[2]  = '{INST_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd33};
    vecs[3]  = '{INST_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 8'd33};
    vecs[4]  = '{INST_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 8'd33};
    vecs[5]  = '{INST_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1};
    vecs[6]  = '{INST_REM,    32'd5,          32'd0,         32'd5,         8'd1};
    vecs[7]  = '{INST_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
    vecs[8]  = '{INST_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         8'd1};
    vecs[9]  = '{INST_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 8'd33};
    vecs[10] = '{INST_DIVU,   32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, 8'd33};
    for (int i = 0; i < 11; i++) begin
      run_op(build_inst(vecs[i].f3, 5'd5), vecs[i].a, vecs[i].b, 5'd5, 1'b1, 1'b1, lat, wd, weo, wa);
      check_count++; if (wd !== vecs[i].exp) $display("[TB] FAIL dir%0d_wdata: got %h expected %h", i, wd, vecs[i].exp); else pass_count++;
      check_count++; if (lat != int'(vecs[i].lat)) $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat); else pass_count++;
      check_count++; if ({weo, wa} !== {1'b1, 5'd5}) $display("[TB] FAIL dir%0d_we_waddr: got %b/%0d expected 1/5", i, weo, wa); else pass_count++;
      @(negedge clk);
      check_count++; if ({ready_o, valid_o} !== 2'b10) $display("[TB] FAIL dir%0d_after_accept: got ready/valid %b%b expected 10", i, ready_o, valid_o); else pass_count++;
    end
  endtask

  task automatic test_rd_zero();
    int lat; logic [31:0] wd; logic weo; logic [4:0] wa;
    run_op(build_inst(INST_MUL, 5'd0), 32'd3, 32'd4, 5'd0, 1'b1, 1'b1, lat, wd, weo, wa);
    check_count++; if (wd !== 32'd12) $display("[TB] FAIL rd0_wdata: got %h expected 0000000c", wd); else pass_count++;
    check_count++; if (weo !== 1'b0) $display("[TB] FAIL rd0_we: got %b expected 0", weo); else pass_count++;
  endtask

  task automatic test_non_m();
    int lat; logic [31:0] wd; logic weo; logic [4:0] wa;
    run_op({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0010011}, 32'd3, 32'd4, 5'd9, 1'b1, 1'b1, lat, wd, weo, wa);
    check_count++; if (lat != 1) $display("[TB] FAIL nonm_latency: got %0d expected 1", lat); else pass_count++;
    check_count++; if ({weo, wd} !== 33'd0) $display("[TB] FAIL nonm_we_wdata: got %b/%h expected 0/0", weo, wd); else pass_count++;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] wd; logic weo; logic [4:0] wa;
    run_op(build_inst(INST_MUL, 5'd3), 32'd123, 32'd456, 5'd3, 1'b1, 1'b0, lat, wd, weo, wa);
    check_count++; if (wd !== 32'd56088) $display("[TB] FAIL bp_wdata: got %h expected %h", wd, 32'd56088); else pass_count++;
    valid_i = 1'b1; inst_i = build_inst(INST_DIVU, 5'd4); op1_i = 32'd1; op2_i = 32'd0; reg_waddr_i = 5'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_count++;
      if ({valid_o, ready_o, reg_wdata_o, reg_waddr_o} !== {1'b1, 1'b0, 32'd56088, 5'd3})
        $display("[TB] FAIL bp_hold%0d: got v=%b r=%b d=%h a=%0d expected v=1 r=0 d=%h a=3", i, valid_o, ready_o, reg_wdata_o, reg_waddr_o, 32'd56088);
      else pass_count++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check_count++; if ({ready_o, valid_o} !== 2'b10) $display("[TB] FAIL bp_release: got ready/valid %b%b expected 10", ready_o, valid_o); else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen, expv;
    @(negedge clk);
    valid_i = 1'b1; ready_i = 1'b1; inst_i = build_inst(INST_DIVU, 5'd6);
    op1_i = 32'd9; op2_i = 32'd0; reg_waddr_i = 5'd6; reg_we_i = 1'b1;
    seen = '0; expv = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen[5-i] = valid_o;
      expv[5-i] = ((i % (LAT_SPECIAL + 1)) == 0);
    end
    valid_i = 1'b0;
    check_count++; if (seen !== expv) $display("[TB] FAIL b2b_pattern: got %b expected %b", seen, expv); else pass_count++;
    check_count++; if (reg_wdata_o !== 32'hFFFF_FFFF) $display("[TB] FAIL b2b_wdata: got %h expected ffffffff", reg_wdata_o); else pass_count++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat; logic [31:0] wd; logic weo; logic [4:0] wa;
    logic [2:0] f3; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: a = 32'd0; 1: a = 32'hFFFF_FFFF; 2: a = 32'h8000_0000; default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0; 1: b = 32'hFFFF_FFFF; 2: b = 32'h8000_0000; default: b = $urandom;
      endcase
      run_op(build_inst(f3, 5'd1), a, b, 5'd1, 1'b1, 1'b1, lat, wd, weo, wa);
      check_count++; if (wd !== ref_result(f3, a, b)) $display("[TB] FAIL rnd%0d_wdata f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, wd, ref_result(f3, a, b)); else pass_count++;
      check_count++; if (lat != ref_latency(f3, a, b)) $display("[TB] FAIL rnd%0d_latency f3=%0d: got %0d expected %0d", i, f3, lat, ref_latency(f3, a, b)); else pass_count++;
    end
  endtask

  task automatic test_flush();
    logic seen_valid;
    @(negedge clk);
    valid_i = 1'b1; ready_i = 1'b1; inst_i = build_inst(INST_DIV, 5'd2);
    op1_i = 32'd1000; op2_i = 32'd7; reg_waddr_i = 5'd2;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check_count++; if (busy_o !== 1'b1) $display("[TB] FAIL flush_busy_before: got %b expected 1", busy_o); else pass_count++;
    flush_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    check_count++; if ({ready_o, busy_o, valid_o} !== 3'b100) $display("[TB] FAIL flush_idle: got r/b/v %b%b%b expected 100", ready_o, busy_o, valid_o); else pass_count++;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    check_count++; if (busy_o !== 1'b0) $display("[TB] FAIL flush_priority: got busy %b expected 0", busy_o); else pass_count++;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_valid |= valid_o;
    end
    check_count++; if (seen_valid !== 1'b0) $display("[TB] FAIL flush_no_result: got valid %b expected 0", seen_valid); else pass_count++;
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] wd; logic weo; logic [4:0] wa;
    @(negedge clk);
    valid_i = 1'b1; ready_i = 1'b1; inst_i = build_inst(INST_MUL, 5'd7);
    op1_i = 32'd11; op2_i = 32'd13; reg_waddr_i = 5'd7; reg_we_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_count++; if ({ready_o, valid_o, busy_o} !== 3'b100) $display("[TB] FAIL areset_state: got r/v/b %b%b%b expected 100", ready_o, valid_o, busy_o); else pass_count++;
    check_count++; if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== 38'd0) $display("[TB] FAIL areset_outputs: got %b/%0d/%h expected 0/0/0", reg_we_o, reg_waddr_o, reg_wdata_o); else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(build_inst(INST_MUL, 5'd7), 32'd6, 32'd7, 5'd7, 1'b1, 1'b1, lat, wd, weo, wa);
    check_count++; if ({wd, lat} !== {32'd42, LAT_ITER}) $display("[TB] FAIL areset_recover: got %h lat %0d expected 0000002a lat %0d", wd, lat, LAT_ITER); else pass_count++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rd_zero();
    test_non_m();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
